// File: rtl/bcd_pulse_counter.sv
// bcd_pulse_counter
//   Multi-digit BCD up/down counter driven by single-cycle button pulses.
//   Wraps at both ends and raises a one-cycle Carry or Borrow flag.
//   Supports a synchronous parallel load that rejects any nibble above 9.
//
// Ports
//   Clk        in   system clock, rising-edge active
//   Reset      in   synchronous active-high reset
//   UpPulse    in   increment request, sampled every edge
//   DownPulse  in   decrement request, sampled every edge
//   Load       in   parallel-load request
//   LoadValue  in   BCD load value, digit 0 in [3:0]
//   Count      out  registered BCD count, digit 0 in [3:0]
//   Carry      out  one-cycle flag after an up-wrap from all-9s to 0
//   Borrow     out  one-cycle flag after a down-wrap from 0 to all-9s
//   LoadError  out  one-cycle flag after a rejected load
module bcd_pulse_counter #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    UpPulse,
  input  logic                    DownPulse,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] LoadValue,
  output logic [4*NUM_DIGITS-1:0] Count,
  output logic                    Carry,
  output logic                    Borrow,
  output logic                    LoadError
);

  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    carry_q, carry_d;
  logic                    borrow_q, borrow_d;
  logic                    lerr_q, lerr_d;

  logic [4*NUM_DIGITS-1:0] inc_val, dec_val;
  logic                    all_nines, all_zeros;
  logic                    load_ok;

  // Ripple through the digits in one cycle.
  // A digit steps only when every lower digit sits at its wrap value.
  // That is 9 when counting up and 0 when counting down.
  always_comb begin
    logic [3:0] dig;
    logic       lower9, lower0;
    inc_val = '0;
    dec_val = '0;
    lower9  = 1'b1;
    lower0  = 1'b1;
    load_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (lower9) inc_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      else        inc_val[4*i +: 4] = dig;
      if (lower0) dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      else        dec_val[4*i +: 4] = dig;
      lower9 = lower9 & (dig == 4'd9);
      lower0 = lower0 & (dig == 4'd0);
      if (LoadValue[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
    all_nines = lower9;
    all_zeros = lower0;
  end

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    lerr_d   = 1'b0;
    if (Load) begin
      if (load_ok) count_d = LoadValue;
      else         lerr_d  = 1'b1;
    end else if (UpPulse && DownPulse) begin
      count_d = count_q;
    end else if (UpPulse) begin
      count_d = inc_val;
      carry_d = all_nines;
    end else if (DownPulse) begin
      count_d  = dec_val;
      borrow_d = all_zeros;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      lerr_q   <= lerr_d;
    end
  end

  assign Count     = count_q;
  assign Carry     = carry_q;
  assign Borrow    = borrow_q;
  assign LoadError = lerr_q;

endmodule

// File: tb/tb_bcd_pulse_counter.sv
// tb_bcd_pulse_counter
//   Directed bench for bcd_pulse_counter with NUM_DIGITS = 4.
//   Expected values are hand-computed BCD constants.
module tb_bcd_pulse_counter;

  logic        Clk;
  logic        Reset;
  logic        UpPulse;
  logic        DownPulse;
  logic        Load;
  logic [15:0] LoadValue;
  logic [15:0] Count;
  logic        Carry;
  logic        Borrow;
  logic        LoadError;

  int n_cmp;
  int n_err;

  bcd_pulse_counter #(.NUM_DIGITS(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .UpPulse   (UpPulse),
    .DownPulse (DownPulse),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Count     (Count),
    .Carry     (Carry),
    .Borrow    (Borrow),
    .LoadError (LoadError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] cnt,
                         input logic c, input logic b, input logic e);
    chk({tag, ".count"},  Count,            cnt);
    chk({tag, ".carry"},  {15'd0, Carry},    {15'd0, c});
    chk({tag, ".borrow"}, {15'd0, Borrow},   {15'd0, b});
    chk({tag, ".lerr"},   {15'd0, LoadError}, {15'd0, e});
  endtask

  // Drive the inputs, take one rising edge, then settle 1 time unit for checks.
  task automatic step(input logic rst, input logic ld, input logic up,
                      input logic dn, input logic [15:0] lv);
    Reset = rst; Load = ld; UpPulse = up; DownPulse = dn; LoadValue = lv;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1; Load = 1'b0; UpPulse = 1'b0; DownPulse = 1'b0; LoadValue = '0;
    #2;

    // Reset overrides a held Up request.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 16'h0000);
      chk_all("rst_up", 16'h0000, 0, 0, 0);
    end
    step(0, 0, 1, 0, 16'h0000);
    chk_all("first_up", 16'h0001, 0, 0, 0);

    // Count up from zero and carry into the tens digit.
    step(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 16'h0000);
    chk_all("up9", 16'h0009, 0, 0, 0);
    step(0, 0, 1, 0, 16'h0000);
    chk_all("up10", 16'h0010, 0, 0, 0);
    step(0, 1, 0, 0, 16'h0999);
    chk_all("ld0999", 16'h0999, 0, 0, 0);
    step(0, 0, 1, 0, 16'h0000);
    chk_all("up1000", 16'h1000, 0, 0, 0);

    // Top wrap: Carry lasts exactly one cycle.
    step(0, 1, 0, 0, 16'h9999);
    chk_all("ld9999", 16'h9999, 0, 0, 0);
    step(0, 0, 1, 0, 16'h0000);
    chk_all("wrap_up", 16'h0000, 1, 0, 0);
    step(0, 0, 1, 0, 16'h0000);
    chk_all("after_wrap", 16'h0001, 0, 0, 0);

    // Bottom wrap: Borrow lasts exactly one cycle.
    step(0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("wrap_dn", 16'h9999, 0, 1, 0);
    step(0, 0, 0, 0, 16'h0000);
    chk_all("idle_dn", 16'h9999, 0, 0, 0);
    step(0, 1, 0, 0, 16'h1000);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("dn0999", 16'h0999, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("dn0998", 16'h0998, 0, 0, 0);

    // Up and Down together hold the count, then Up held for 5 cycles.
    step(0, 1, 0, 0, 16'h0042);
    step(0, 0, 1, 1, 16'h0000);
    chk_all("both", 16'h0042, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'h0000);
    chk_all("held5", 16'h0047, 0, 0, 0);

    // Loads: a valid load, an invalid load, then a load on an all-9s Up edge.
    step(0, 1, 0, 0, 16'h1234);
    chk_all("ld1234", 16'h1234, 0, 0, 0);
    step(0, 1, 0, 0, 16'h12A4);
    chk_all("ld_bad", 16'h1234, 0, 0, 1);
    step(0, 0, 0, 0, 16'h0000);
    chk_all("ld_bad_clr", 16'h1234, 0, 0, 0);
    step(0, 1, 1, 0, 16'hF000);
    chk_all("ld_bad_up", 16'h1234, 0, 0, 1);
    step(0, 1, 0, 0, 16'h9999);
    step(0, 1, 1, 0, 16'h5678);
    chk_all("ld_at_wrap", 16'h5678, 0, 0, 0);

    // Reset mid-operation beats a concurrent Load.
    step(1, 1, 0, 0, 16'h4321);
    chk_all("rst_ld", 16'h0000, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("rst_then_dn", 16'h9999, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
